// File: rtl/gen_if.sv
// gen_if: control inputs and Moore status outputs of the life-array generation sequencer
interface gen_if #(
  parameter int POS_W = 2,
  parameter int GEN_W = 8
);
  logic start;
  logic single_step;
  logic pause;
  logic write_array;
  logic write_mem;
  logic run;
  logic [POS_W-1:0] pos;
  logic busy;
  logic gen_done;
  logic [GEN_W-1:0] generation;
  modport master (
    output start, single_step, pause,
    input  write_array, write_mem, run, pos, busy, gen_done, generation
  );
  modport slave (
    input  start, single_step, pause,
    output write_array, write_mem, run, pos, busy, gen_done, generation
  );
endinterface

// File: rtl/gen_controller.sv
// gen_controller: sweeps cell positions through fetch/write_array/settle/write_mem, then a run window per generation
module gen_controller #(
  parameter int N_POS         = 4,
  parameter int POS_W         = 2,
  parameter int SETTLE_CYCLES = 1,
  parameter int RUN_CYCLES    = 1,
  parameter int GEN_W         = 8,
  parameter int AUTO_START    = 1
) (
  input logic clk,
  input logic reset,
  gen_if.slave bus
);
  localparam logic [2:0] IDLE        = 3'd0;
  localparam logic [2:0] FETCH       = 3'd1;
  localparam logic [2:0] WRITE_ARRAY = 3'd2;
  localparam logic [2:0] SETTLE      = 3'd3;
  localparam logic [2:0] WRITE_MEM   = 3'd4;
  localparam logic [2:0] RUN         = 3'd5;
  localparam logic [2:0] RST_STATE   = (AUTO_START != 0) ? FETCH : IDLE;
  localparam int SW = $clog2(SETTLE_CYCLES + 1);
  localparam int RW = $clog2(RUN_CYCLES + 1);
  logic [2:0] state, state_nx;
  logic [SW-1:0] settle_cnt;
  logic [RW-1:0] run_cnt;
  logic [POS_W-1:0] pos;
  logic [GEN_W-1:0] generation;
  logic settle_last, run_last, pos_last, cont, gen_end;
  assign settle_last = settle_cnt == SW'(SETTLE_CYCLES - 1);
  assign run_last    = run_cnt == RW'(RUN_CYCLES - 1);
  assign pos_last    = pos == POS_W'(N_POS - 1);
  assign cont        = (AUTO_START != 0) || bus.start;
  assign gen_end     = state == RUN && run_last;
  always_comb begin
    state_nx = IDLE;
    case (state)
      IDLE:        state_nx = (bus.start || bus.single_step) ? FETCH : IDLE;
      FETCH:       state_nx = WRITE_ARRAY;
      WRITE_ARRAY: state_nx = SETTLE;
      SETTLE:      state_nx = settle_last ? WRITE_MEM : SETTLE;
      WRITE_MEM:   state_nx = pos_last ? RUN : FETCH;
      RUN:         state_nx = run_last ? (cont ? FETCH : IDLE) : RUN;
      default:     state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= RST_STATE;
      settle_cnt <= '0;
      run_cnt    <= '0;
      pos        <= '0;
      generation <= '0;
    end else if (!bus.pause) begin
      state      <= state_nx;
      settle_cnt <= (state == SETTLE && !settle_last) ? settle_cnt + 1'b1 : '0;
      run_cnt    <= (state == RUN && !run_last) ? run_cnt + 1'b1 : '0;
      pos        <= (state == WRITE_MEM && !pos_last) ? pos + 1'b1 : gen_end ? '0 : pos;
      generation <= gen_end ? generation + 1'b1 : generation;
    end
  end
  assign bus.write_array = state == WRITE_ARRAY;
  assign bus.write_mem   = state == WRITE_MEM;
  assign bus.run         = state == RUN;
  assign bus.busy        = state != IDLE;
  assign bus.gen_done    = gen_end;
  assign bus.pos         = pos;
  assign bus.generation  = generation;
endmodule
